// File: rtl/ysyx_22040759_wb_arb_pkg.sv
// Shared definitions for the WB / MDU register-file write arbiter:
// bus field offsets, write-port selector codes and the MDU FIFO entry layout.
package ysyx_22040759_wb_arb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned RF_AW = 5;
  localparam int unsigned NREG  = 32;

  // ws_to_rf_bus layout: {wen, waddr, wdata}
  localparam int unsigned WB_BUS_W     = 1 + RF_AW + XLEN;
  localparam int unsigned WB_WEN_BIT   = 69;
  localparam int unsigned WB_WADDR_LSB = 64;
  localparam int unsigned WB_WDATA_LSB = 0;

  typedef enum logic [1:0] {
    WREG_NONE = 2'd0,
    WREG_WB   = 2'd1,
    WREG_MDU  = 2'd2
  } wreg_sel_e;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } mdu_ent_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [RF_AW-1:0] r);
    return NREG'(1) << r;
  endfunction

endpackage

// File: rtl/ysyx_22040759_wb_fifo.sv
// MDU result FIFO: DEPTH entries of {rd, data}, with per-slot occupancy and rd
// exported so the arbiter can build the pending-register mask.
module ysyx_22040759_wb_fifo
  import ysyx_22040759_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  mdu_ent_t                          push_ent,
  input  logic                              pop,
  output mdu_ent_t                          head,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0]                  ent_vld,
  output logic [DEPTH-1:0][RF_AW-1:0]       ent_rd
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;
  mdu_ent_t         mem [DEPTH];

  // Guard against overflow / underflow even if the caller misbehaves.
  assign do_push = push && (cnt < CNT_W'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    ent_vld = '0;
    ent_rd  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_vld[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < cnt;
      ent_rd[i]  = mem[i].rd;
    end
  end

endmodule

// File: rtl/ysyx_22040759_wb_arb.sv
// Register-file write-port arbiter: WB stage writes win outright, queued MDU
// results fill idle slots, and a starving FIFO head raises wb_hold.
module ysyx_22040759_wb_arb
  import ysyx_22040759_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WB_BUS_W-1:0] ws_to_rf_bus,
  input  logic                mdu_valid,
  input  logic [RF_AW-1:0]    mdu_rd,
  input  logic [XLEN-1:0]     mdu_result,
  output logic                mdu_ready,
  output logic                rf_wen,
  output logic [RF_AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                wb_hold,
  output logic [NREG-1:0]     pending_mask
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ST_W  = $clog2(STARVE_MAX) + 1;
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARVE_MAX - 1);

  logic                        wb_wen;
  logic [RF_AW-1:0]            wb_waddr;
  logic [XLEN-1:0]             wb_wdata;
  logic                        wb_win;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  mdu_ent_t                    push_ent;
  mdu_ent_t                    head;
  logic [CNT_W-1:0]            fifo_cnt;
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][RF_AW-1:0] ent_rd;
  wreg_sel_e                   sel;
  logic [ST_W-1:0]             starve_q;
  logic [ST_W-1:0]             starve_d;
  logic                        hold_d;
  logic [NREG-1:0]             mask_c;

  assign wb_wen   = ws_to_rf_bus[WB_WEN_BIT];
  assign wb_waddr = ws_to_rf_bus[WB_WADDR_LSB +: RF_AW];
  assign wb_wdata = ws_to_rf_bus[WB_WDATA_LSB +: XLEN];

  // Writes to x0 are no-ops; they never claim the port.
  assign wb_win     = rst_n && wb_wen && (wb_waddr != '0);
  assign fifo_empty = (fifo_cnt == '0);
  assign mdu_ready  = fifo_cnt < CNT_W'(DEPTH);
  assign push       = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign pop        = !wb_win && !fifo_empty;
  assign push_ent   = '{rd: mdu_rd, data: mdu_result};

  ysyx_22040759_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .count    (fifo_cnt),
    .ent_vld  (ent_vld),
    .ent_rd   (ent_rd)
  );

  always_comb begin
    sel = WREG_NONE;
    if (wb_win)           sel = WREG_WB;
    else if (!fifo_empty) sel = WREG_MDU;
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (sel)
      WREG_WB: begin
        rf_wen   = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
      WREG_MDU: begin
        rf_wen   = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  // Counter saturates at STARVE_MAX-1; hold stays up until the head drains.
  always_comb begin
    starve_d = starve_q;
    hold_d   = wb_hold;
    if (pop || fifo_empty) starve_d = '0;
    else if (starve_q != ST_LAST) starve_d = starve_q + ST_W'(1);
    if (pop) hold_d = 1'b0;
    else if (!fifo_empty && (starve_q == ST_LAST)) hold_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      wb_hold  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wb_hold  <= hold_d;
    end
  end

  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) mask_c = mask_c | reg_onehot(ent_rd[i]);
    end
  end

  assign pending_mask = {mask_c[NREG-1:1], 1'b0};

endmodule

// File: tb/tb_ysyx_22040759_wb_arb.sv
// Self-checking bench: queue-based model of the arbiter, directed scenarios
// with literal expectations, randomized traffic, and a mid-run reset.
module tb_ysyx_22040759_wb_arb;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [69:0] ws_to_rf_bus;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_result;
  logic        mdu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_hold;
  logic [31:0] pending_mask;

  always #5 clk = ~clk;

  ysyx_22040759_wb_arb #(
    .DEPTH(DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ws_to_rf_bus (ws_to_rf_bus),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_result   (mdu_result),
    .mdu_ready    (mdu_ready),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_hold      (wb_hold),
    .pending_mask (pending_mask)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ment_t;

  ment_t q[$];
  int    head_age;
  int    checks;
  int    errors;

  logic        s_wen, s_ready, s_hold;
  logic [4:0]  s_addr;
  logic [63:0] s_data;
  logic [31:0] s_mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic wen, input logic [4:0] waddr, input logic [63:0] wdata,
                      input logic mv, input logic [4:0] mrd, input logic [63:0] mres);
    logic        wb_win, pop, push;
    logic        e_wen;
    logic [4:0]  e_addr;
    logic [63:0] e_data;
    logic [31:0] e_mask;
    @(negedge clk);
    ws_to_rf_bus = {wen, waddr, wdata};
    mdu_valid    = mv;
    mdu_rd       = mrd;
    mdu_result   = mres;
    #1;
    s_wen = rf_wen; s_addr = rf_waddr; s_data = rf_wdata;
    s_ready = mdu_ready; s_hold = wb_hold; s_mask = pending_mask;

    wb_win = wen && (waddr != 5'd0);
    e_wen = 1'b0; e_addr = '0; e_data = '0;
    if (wb_win) begin
      e_wen = 1'b1; e_addr = waddr; e_data = wdata;
    end else if (q.size() > 0) begin
      e_wen = 1'b1; e_addr = q[0].rd; e_data = q[0].data;
    end
    e_mask = '0;
    foreach (q[k]) e_mask = e_mask | (32'd1 << q[k].rd);

    chk("rf_wen", 64'(s_wen), 64'(e_wen));
    chk("rf_waddr", 64'(s_addr), 64'(e_addr));
    chk("rf_wdata", s_data, e_data);
    chk("mdu_ready", 64'(s_ready), 64'(q.size() < DEPTH));
    chk("wb_hold", 64'(s_hold), 64'(q.size() > 0 && head_age >= STARVE_MAX));
    chk("pending_mask", 64'(s_mask), 64'(e_mask));

    pop  = !wb_win && (q.size() > 0);
    push = mv && (q.size() < DEPTH) && (mrd != 5'd0);
    @(posedge clk);
    if (q.size() > 0 && !pop) head_age++;
    else head_age = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{rd: mrd, data: mres});
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_wen"}, 64'(rf_wen), 64'd0);
    chk({tag, "_ready"}, 64'(mdu_ready), 64'd1);
    chk({tag, "_hold"}, 64'(wb_hold), 64'd0);
    chk({tag, "_mask"}, 64'(pending_mask), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; head_age = 0;
    ws_to_rf_bus = '0; mdu_valid = 1'b0; mdu_rd = '0; mdu_result = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // WB write passes through with zero latency.
    step(1'b1, 5'd5, 64'h11, 1'b0, 5'd0, 64'd0);
    chk("wb_pass_wen", 64'(s_wen), 64'd1);
    chk("wb_pass_addr", 64'(s_addr), 64'd5);
    chk("wb_pass_data", s_data, 64'h11);

    // Single MDU result writes back one cycle later; mask bit 7 for one cycle.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAB);
    chk("mdu_push_cycle_wen", 64'(s_wen), 64'd0);
    idle();
    chk("mdu_wb_addr", 64'(s_addr), 64'd7);
    chk("mdu_wb_data", s_data, 64'hAB);
    chk("mdu_mask7", 64'(s_mask), 64'h80);
    idle();
    chk("mdu_mask_clear", 64'(s_mask), 64'd0);
    chk("mdu_done_wen", 64'(s_wen), 64'd0);

    // Two pushes under continuous WB writes fill the FIFO; drain in order.
    step(1'b1, 5'd1, 64'h100, 1'b1, 5'd3, 64'h333);
    step(1'b1, 5'd2, 64'h200, 1'b1, 5'd4, 64'h444);
    chk("fill_ready_before_2nd", 64'(s_ready), 64'd1);
    step(1'b1, 5'd1, 64'h101, 1'b0, 5'd0, 64'd0);
    chk("full_ready", 64'(s_ready), 64'd0);
    chk("full_mask", 64'(s_mask), 64'h18);
    idle();
    chk("drain_first", 64'(s_addr), 64'd3);
    idle();
    chk("drain_second", 64'(s_addr), 64'd4);
    chk("drain_second_data", s_data, 64'h444);
    idle();
    chk("drained_wen", 64'(s_wen), 64'd0);

    // Head starved by WB writes raises wb_hold after 8 waiting cycles.
    step(1'b1, 5'd9, 64'h9, 1'b1, 5'd6, 64'h66);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'd9, 64'(i), 1'b0, 5'd0, 64'd0);
      chk("starve_no_hold_yet", 64'(s_hold), 64'd0);
    end
    step(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0);
    chk("starve_hold_set", 64'(s_hold), 64'd1);
    chk("starve_wb_still_wins", 64'(s_addr), 64'd9);
    idle();
    chk("starve_pop_addr", 64'(s_addr), 64'd6);
    chk("starve_hold_on_pop", 64'(s_hold), 64'd1);
    idle();
    chk("starve_hold_clear", 64'(s_hold), 64'd0);

    // rd=0 results are accepted and dropped.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55);
    chk("rd0_ready", 64'(s_ready), 64'd1);
    idle();
    chk("rd0_no_write", 64'(s_wen), 64'd0);
    chk("rd0_mask", 64'(s_mask), 64'd0);

    // Randomized traffic with varying WB pressure.
    for (int n = 0; n < 1500; n++) begin
      int unsigned pct;
      pct = ((n / 250) % 3 == 0) ? 30 : (((n / 250) % 3 == 1) ? 70 : 95);
      step($urandom_range(99) < pct, 5'($urandom_range(31)), {$urandom, $urandom},
           $urandom_range(1), 5'($urandom_range(31)), {$urandom, $urandom});
    end

    // Reset with a full FIFO discards everything.
    step(1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 64'hA0);
    step(1'b1, 5'd1, 64'h2, 1'b1, 5'd11, 64'hB0);
    step(1'b1, 5'd1, 64'h3, 1'b0, 5'd0, 64'd0);
    chk("pre_reset_full", 64'(s_ready), 64'd0);
    @(negedge clk);
    ws_to_rf_bus = {1'b1, 5'd3, 64'h77};
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    q.delete();
    head_age = 0;
    @(negedge clk);
    ws_to_rf_bus = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_reset_no_write", 64'(s_wen), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
